multi_cycle_ctrl: RTL and testbench

//  Multi-cycle FSM controller. Sequences the shared datapath (PC, IR, regfile, ALU, unified memory) for the 4-bit-opcode ISA: R-type 0000, lw 0001, sw 0010, beq 0011.

---
 rtl/multi_cycle_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle controller for the 4-bit-opcode ISA (R-type, lw, sw, beq).
// Sequences FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready, traps, counts retires.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   run                   start fetching from IDLE
//   opcode                IR[15:12], stable from DECODE until the instruction retires
//   zero                  ALU zero flag (the datapath gates PcWriteCond with it)
//   mem_ready             memory completes the current access this cycle
//   PcWrite..AluOp        datapath controls
//   err, err_code         sticky trap flag and cause (01 illegal, 10 timeout)
//   retired               retired-instruction count, wraps
//   state                 current state (debug)
module multi_cycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PcWrite,
    output logic             PcWriteCond,
    output logic [1:0]       PcSrc,
    output logic             IorD,
    output logic             IrWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic             extOp,
    output logic [2:0]       AluOp,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [3:0] OP_R  = 4'd0;
    localparam logic [3:0] OP_LW = 4'd1;
    localparam logic [3:0] OP_SW = 4'd2;

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_t          cur;
    state_t          nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            err_q;
    logic [1:0]      code_q;
    logic [1:0]      code_nxt;
    logic [CNT_W-1:0] ret_q;
    logic            retire;
    logic            timeout;
    logic            is_lw;

    // The branch decision itself is made in the datapath (PcWriteCond & zero).
    logic unused_zero;
    assign unused_zero = zero;

    assign is_lw   = (opcode == OP_LW);
    // Last permitted waiting cycle; a ready on this cycle still wins.
    assign timeout = !mem_ready && (wait_cnt == WC_LAST);

    always_comb begin
        nxt         = cur;
        code_nxt    = 2'b00;
        retire      = 1'b0;
        PcWrite     = 1'b0;
        PcWriteCond = 1'b0;
        PcSrc       = 2'b00;
        IorD        = 1'b0;
        IrWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        AluSrcA     = 1'b0;
        AluSrcB     = 2'b00;
        extOp       = 1'b0;
        AluOp       = 3'b000;
        case (cur)
            S_IDLE: begin
                if (run) nxt = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                AluSrcB = 2'b01;
                AluOp   = 3'b001;
                if (mem_ready) begin
                    IrWrite = 1'b1;
                    PcWrite = 1'b1;
                    nxt     = S_DECODE;
                end else if (timeout) begin
                    nxt      = S_ERR;
                    code_nxt = 2'b10;
                end
            end
            S_DECODE: begin
                AluSrcB = 2'b10;
                extOp   = 1'b1;
                AluOp   = 3'b001;
                if (opcode[3:2] == 2'b00) begin
                    nxt = S_EXEC;
                end else begin
                    nxt      = S_ERR;
                    code_nxt = 2'b01;
                end
            end
            S_EXEC: begin
                AluSrcA = 1'b1;
                if (opcode == OP_R) begin
                    AluOp = 3'b100;
                    nxt   = S_WB;
                end else if (is_lw || opcode == OP_SW) begin
                    AluSrcB = 2'b10;
                    extOp   = 1'b1;
                    AluOp   = 3'b001;
                    nxt     = S_MEM;
                end else begin
                    AluOp       = 3'b010;
                    PcWriteCond = 1'b1;
                    PcSrc       = 2'b01;
                    nxt         = S_FETCH;
                    retire      = 1'b1;
                end
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = is_lw;
                MemWrite = !is_lw;
                if (mem_ready) begin
                    if (is_lw) begin
                        nxt = S_WB;
                    end else begin
                        nxt    = S_FETCH;
                        retire = 1'b1;
                    end
                end else if (timeout) begin
                    nxt      = S_ERR;
                    code_nxt = 2'b10;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemToReg = is_lw;
                RegDst   = !is_lw;
                nxt      = S_FETCH;
                retire   = 1'b1;
            end
            S_ERR: begin
                nxt = S_ERR;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= S_IDLE;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
            ret_q    <= '0;
        end else begin
            cur <= nxt;
            if (nxt == S_ERR && cur != S_ERR) begin
                err_q  <= 1'b1;
                code_q <= code_nxt;
            end
            if (retire) ret_q <= ret_q + 1'b1;
            // Any state change restarts the wait window.
            if (nxt != cur) begin
                wait_cnt <= '0;
            end else if ((cur == S_FETCH || cur == S_MEM) && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign err      = err_q;
    assign err_code = code_q;
    assign retired  = ret_q;
    assign state    = cur;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl (MEM_TIMEOUT=4, CNT_W=2).
// Directed vector table, hand-written corner sequences, random run vs queue model.
module tb_multi_cycle_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;
    logic PcWrite, PcWriteCond, IorD, IrWrite, MemRead, MemWrite;
    logic MemToReg, RegDst, RegWrite, AluSrcA, extOp, err;
    logic [1:0] PcSrc, AluSrcB, err_code;
    logic [2:0] AluOp, state;
    logic [CW-1:0] retired;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .zero(zero), .mem_ready(mem_ready),
        .PcWrite(PcWrite), .PcWriteCond(PcWriteCond), .PcSrc(PcSrc),
        .IorD(IorD), .IrWrite(IrWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
        .extOp(extOp), .AluOp(AluOp), .err(err), .err_code(err_code),
        .retired(retired), .state(state)
    );

    typedef struct packed {
        logic pcw; logic pcwc; logic [1:0] pcsrc; logic iord; logic irw;
        logic mr; logic mw; logic m2r; logic rdst; logic rw; logic asa;
        logic [1:0] asb; logic ext; logic [2:0] aop;
    } ctl_t;

    ctl_t act;
    assign act = {PcWrite, PcWriteCond, PcSrc, IorD, IrWrite, MemRead,
                  MemWrite, MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB,
                  extOp, AluOp};

    localparam int K_IDLE = 0, K_FNR = 1, K_FR = 2, K_DEC = 3, K_EXR = 4;
    localparam int K_EXM = 5, K_EXB = 6, K_MLW = 7, K_MSW = 8, K_WBR = 9;
    localparam int K_WBL = 10;

    function automatic ctl_t kctl(int k);
        ctl_t c = '0;
        case (k)
            K_FNR: begin c.mr = 1'b1; c.asb = 2'b01; c.aop = 3'b001; end
            K_FR: begin
                c.mr = 1'b1; c.asb = 2'b01; c.aop = 3'b001;
                c.irw = 1'b1; c.pcw = 1'b1;
            end
            K_DEC: begin c.asb = 2'b10; c.ext = 1'b1; c.aop = 3'b001; end
            K_EXR: begin c.asa = 1'b1; c.aop = 3'b100; end
            K_EXM: begin
                c.asa = 1'b1; c.asb = 2'b10; c.ext = 1'b1; c.aop = 3'b001;
            end
            K_EXB: begin
                c.asa = 1'b1; c.aop = 3'b010; c.pcwc = 1'b1; c.pcsrc = 2'b01;
            end
            K_MLW: begin c.iord = 1'b1; c.mr = 1'b1; end
            K_MSW: begin c.iord = 1'b1; c.mw = 1'b1; end
            K_WBR: begin c.rw = 1'b1; c.rdst = 1'b1; end
            K_WBL: begin c.rw = 1'b1; c.m2r = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic chk(string nm, logic [2:0] st, int k, logic e,
                       logic [1:0] code, logic [CW-1:0] ret);
        ctl_t c;
        c = kctl(k);
        checks++;
        if (state !== st || act !== c || err !== e || err_code !== code ||
            retired !== ret) begin
            failures++;
            $display("FAIL %s: got st=%0d ctl=%h err=%b code=%b ret=%0d want st=%0d ctl=%h err=%b code=%b ret=%0d",
                     nm, state, act, err, err_code, retired,
                     st, c, e, code, ret);
        end
    endtask

    task automatic drv(logic r, logic [3:0] o, logic z, logic m);
        @(negedge clk);
        run = r; opcode = o; zero = z; mem_ready = m;
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int m_mode;          // 0 idle, 1 running, 2 trapped
    int q[$];            // remaining steps of current instruction, q[0] active
    int m_wait;
    int m_ret;
    logic [1:0] m_code;
    logic [3:0] m_op;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        m_mode = 0; q = {}; m_wait = 0; m_ret = 0; m_code = 2'b00;
        m_op = 4'd0;
    endtask

    function automatic int m_kind(logic rdy);
        if (m_mode != 1) return K_IDLE;
        case (q[0])
            1: return rdy ? K_FR : K_FNR;
            2: return K_DEC;
            3: return (m_op == 4'd0) ? K_EXR : (m_op == 4'd3) ? K_EXB : K_EXM;
            4: return (m_op == 4'd1) ? K_MLW : K_MSW;
            5: return (m_op == 4'd1) ? K_WBL : K_WBR;
            default: return K_IDLE;
        endcase
    endfunction

    function automatic logic [2:0] m_state();
        if (m_mode == 0) return 3'd0;
        if (m_mode == 2) return 3'd7;
        return 3'(q[0]);
    endfunction

    task automatic m_step(logic r, logic [3:0] op, logic rdy);
        int cur;
        bit done;
        if (m_mode == 0) begin
            if (r) begin m_mode = 1; q = {1}; m_wait = 0; end
            return;
        end
        if (m_mode == 2) return;
        cur = q[0];
        done = 1'b0;
        if (cur == 1 || cur == 4) begin
            if (rdy) done = 1'b1;
            else begin
                m_wait++;
                if (m_wait >= TMO) begin m_mode = 2; m_code = 2'b10; return; end
            end
        end else if (cur == 2) begin
            if (op < 4'd4) begin done = 1'b1; m_op = op; end
            else begin m_mode = 2; m_code = 2'b01; return; end
        end else begin
            done = 1'b1;
        end
        if (done) begin
            void'(q.pop_front());
            m_wait = 0;
            if (cur == 1) q.push_back(2);
            else if (cur == 2) begin
                case (op)
                    4'd0: begin q.push_back(3); q.push_back(5); end
                    4'd1: begin q.push_back(3); q.push_back(4); q.push_back(5); end
                    4'd2: begin q.push_back(3); q.push_back(4); end
                    default: q.push_back(3);
                endcase
            end
            if (q.size() == 0) begin
                m_ret++;
                q.push_back(1);
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic run; logic [3:0] op; logic z; logic rdy;
        logic [2:0] st; int k; logic [CW-1:0] ret;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [3:0] cop;
        tbl[0]  = '{1'b1, 4'd0, 1'b0, 1'b1, 3'd0, K_IDLE, 2'd0};
        tbl[1]  = '{1'b0, 4'd0, 1'b0, 1'b1, 3'd1, K_FR,   2'd0};
        tbl[2]  = '{1'b0, 4'd0, 1'b0, 1'b1, 3'd2, K_DEC,  2'd0};
        tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b1, 3'd3, K_EXR,  2'd0};
        tbl[4]  = '{1'b0, 4'd0, 1'b0, 1'b1, 3'd5, K_WBR,  2'd0};
        tbl[5]  = '{1'b0, 4'd1, 1'b0, 1'b1, 3'd1, K_FR,   2'd1};
        tbl[6]  = '{1'b0, 4'd1, 1'b0, 1'b1, 3'd2, K_DEC,  2'd1};
        tbl[7]  = '{1'b0, 4'd1, 1'b0, 1'b1, 3'd3, K_EXM,  2'd1};
        tbl[8]  = '{1'b0, 4'd1, 1'b0, 1'b0, 3'd4, K_MLW,  2'd1};
        tbl[9]  = '{1'b0, 4'd1, 1'b0, 1'b0, 3'd4, K_MLW,  2'd1};
        tbl[10] = '{1'b0, 4'd1, 1'b0, 1'b0, 3'd4, K_MLW,  2'd1};
        tbl[11] = '{1'b0, 4'd1, 1'b0, 1'b1, 3'd4, K_MLW,  2'd1};
        tbl[12] = '{1'b0, 4'd1, 1'b0, 1'b1, 3'd5, K_WBL,  2'd1};
        tbl[13] = '{1'b0, 4'd3, 1'b1, 1'b1, 3'd1, K_FR,   2'd2};
        tbl[14] = '{1'b0, 4'd3, 1'b1, 1'b1, 3'd2, K_DEC,  2'd2};
        tbl[15] = '{1'b0, 4'd3, 1'b1, 1'b1, 3'd3, K_EXB,  2'd2};
        tbl[16] = '{1'b0, 4'd3, 1'b0, 1'b1, 3'd1, K_FR,   2'd3};
        tbl[17] = '{1'b0, 4'd3, 1'b0, 1'b1, 3'd2, K_DEC,  2'd3};
        tbl[18] = '{1'b0, 4'd3, 1'b0, 1'b1, 3'd3, K_EXB,  2'd3};
        tbl[19] = '{1'b0, 4'd0, 1'b0, 1'b1, 3'd1, K_FR,   2'd0};

        do_reset();
        chk("reset", 3'd0, K_IDLE, 1'b0, 2'b00, 2'd0);

        for (int i = 0; i < 20; i++) begin
            drv(tbl[i].run, tbl[i].op, tbl[i].z, tbl[i].rdy);
            chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].k, 1'b0, 2'b00,
                tbl[i].ret);
        end

        // illegal opcode trap, held despite run
        do_reset();
        drv(1'b1, 4'd0, 1'b0, 1'b1);
        chk("ill_idle", 3'd0, K_IDLE, 1'b0, 2'b00, 2'd0);
        drv(1'b0, 4'd0, 1'b0, 1'b1);
        chk("ill_fetch", 3'd1, K_FR, 1'b0, 2'b00, 2'd0);
        drv(1'b0, 4'd7, 1'b0, 1'b1);
        chk("ill_dec", 3'd2, K_DEC, 1'b0, 2'b00, 2'd0);
        for (int i = 0; i < 20; i++) begin
            drv(1'b1, 4'($urandom_range(0, 15)), 1'($urandom),
                1'($urandom));
            chk("ill_hold", 3'd7, K_IDLE, 1'b1, 2'b01, 2'd0);
        end

        // fetch timeout
        do_reset();
        drv(1'b1, 4'd0, 1'b0, 1'b0);
        chk("tmo_idle", 3'd0, K_IDLE, 1'b0, 2'b00, 2'd0);
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 4'd0, 1'b0, 1'b0);
            chk($sformatf("tmo_wait%0d", i), 3'd1, K_FNR, 1'b0, 2'b00, 2'd0);
        end
        drv(1'b1, 4'd0, 1'b0, 1'b0);
        chk("tmo_err", 3'd7, K_IDLE, 1'b1, 2'b10, 2'd0);

        // ready on the last allowed cycle wins
        do_reset();
        drv(1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 4'd2, 1'b0, 1'b0);
            chk($sformatf("late_wait%0d", i), 3'd1, K_FNR, 1'b0, 2'b00, 2'd0);
        end
        drv(1'b0, 4'd2, 1'b0, 1'b1);
        chk("late_rdy", 3'd1, K_FR, 1'b0, 2'b00, 2'd0);
        drv(1'b0, 4'd2, 1'b0, 1'b1);
        chk("late_dec", 3'd2, K_DEC, 1'b0, 2'b00, 2'd0);

        // five stores with counter wrap, then reset mid-MEM
        do_reset();
        drv(1'b1, 4'd2, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 4'd2, 1'b0, 1'b1);
            chk($sformatf("sw%0d_fetch", i), 3'd1, K_FR, 1'b0, 2'b00, CW'(i));
            drv(1'b0, 4'd2, 1'b0, 1'b1);
            drv(1'b0, 4'd2, 1'b0, 1'b1);
            chk($sformatf("sw%0d_exec", i), 3'd3, K_EXM, 1'b0, 2'b00, CW'(i));
            drv(1'b0, 4'd2, 1'b0, 1'b1);
            chk($sformatf("sw%0d_mem", i), 3'd4, K_MSW, 1'b0, 2'b00, CW'(i));
        end
        drv(1'b0, 4'd2, 1'b0, 1'b1);
        chk("sw5_fetch", 3'd1, K_FR, 1'b0, 2'b00, 2'd1);
        drv(1'b0, 4'd2, 1'b0, 1'b1);
        drv(1'b0, 4'd2, 1'b0, 1'b1);
        drv(1'b0, 4'd2, 1'b0, 1'b0);
        chk("sw5_mem", 3'd4, K_MSW, 1'b0, 2'b00, 2'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst", 3'd0, K_IDLE, 1'b0, 2'b00, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // random run against the model
        for (int ep = 0; ep < 12; ep++) begin
            do_reset();
            cop = 4'd0;
            for (int c = 0; c < 150; c++) begin
                logic r, z, rdy;
                if (m_mode != 1 || q[0] == 1) begin
                    if ($urandom_range(0, 31) == 0)
                        cop = 4'($urandom_range(4, 15));
                    else
                        cop = 4'($urandom_range(0, 3));
                end
                r   = 1'($urandom);
                z   = 1'($urandom);
                rdy = ($urandom_range(0, 9) < 7);
                drv(r, cop, z, rdy);
                chk($sformatf("rand%0d_%0d", ep, c), m_state(), m_kind(rdy),
                    (m_mode == 2), m_code, CW'(m_ret));
                m_step(r, cop, rdy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
